// File: rtl/culsans_pkg.sv
// Shared types for the culsans memory responder: AXI/ACE channel structs,
// response codes, burst encodings and the responder FSM state type.
package culsans_pkg;

  localparam logic [63:0] DRAMBase         = 64'h0000_0000_8000_0000;
  localparam int unsigned MemRespWordBytes = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_code_t;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} mem_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [2:0]  snoop;
    logic [1:0]  bar;
    logic [1:0]  domain;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  snoop;
    logic [1:0]  bar;
    logic [1:0]  domain;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  // resp[3:2] carry ACE IsShared/PassDirty, always 0 from this memory.
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_slv_t;

  // DECERR outranks SLVERR once either has been seen in a transaction.
  function automatic resp_code_t err_code(input logic slverr, input logic decerr);
    if (decerr) return RESP_DECERR;
    if (slverr) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/culsans_mem_bank.sv
// Byte-enabled flop storage: one write port, one combinational read port.
// Contents are deliberately not reset so data survives a responder reset.
module culsans_mem_bank
  import culsans_pkg::*;
#(
  parameter int unsigned Words = 4096
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(Words)-1:0]     widx_i,
  input  logic [63:0]                  wdata_i,
  input  logic [MemRespWordBytes-1:0]  be_i,
  input  logic [$clog2(Words)-1:0]     ridx_i,
  output logic [63:0]                  rdata_o
);

  logic [63:0] mem_q [Words];

  // Merge the enabled bytes of the write word into storage.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < MemRespWordBytes; b++) begin
        if (be_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/culsans_axi_mem_responder.sv
// Single-outstanding AXI/ACE memory responder for the DRAM window.
// Reads and writes are granted round-robin; ACE snoop fields are ignored.
module culsans_axi_mem_responder
  import culsans_pkg::*;
#(
  parameter int unsigned MemWords = 4096,
  parameter logic [63:0] BaseAddr = DRAMBase
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  req_slv_t  req_i,
  output resp_slv_t resp_o
);

  localparam int unsigned IdxW    = $clog2(MemWords);
  localparam logic [64:0] BaseExt = {1'b0, BaseAddr};
  localparam logic [64:0] EndExt  = BaseExt + 65'(MemWords) * 65'(MemRespWordBytes);

  // Attribute errors known at address acceptance time.
  function automatic logic attr_err(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [7:0] len, input logic [5:0] atop);
    return (burst == BURST_WRAP) || ((size < 3'd3) && (len != 8'd0)) ||
           (size > 3'd3) || (atop != 6'd0);
  endfunction

  mem_state_e  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  id_q, id_d;
  logic [64:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;
  logic [1:0]  burst_q, burst_d;
  logic        slverr_q, slverr_d;
  logic        decerr_q, decerr_d;

  logic [64:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] mem_idx;
  logic [64:0]     addr_next;
  logic [7:0]      beat_next;
  logic            mem_we;
  logic [63:0]     mem_rdata;
  logic            grant_w, grant_r, mism, slv_beat, dec_beat;

  // Address kept 65 bits wide so the range test and increment never wrap.
  assign offset    = addr_q - BaseExt;
  assign in_range  = (addr_q >= BaseExt) && (addr_q < EndExt);
  assign mem_idx   = offset[IdxW+2:3];
  assign addr_next = (burst_q == BURST_INCR) ? addr_q + 65'(MemRespWordBytes) : addr_q;
  assign beat_next = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;

  logic unused_bits;
  assign unused_bits = ^{offset[64:IdxW+3], offset[2:0], req_i.aw.snoop, req_i.aw.bar,
                         req_i.aw.domain, req_i.aw.user, req_i.ar.snoop, req_i.ar.bar,
                         req_i.ar.domain, req_i.ar.user, req_i.w.user};

  culsans_mem_bank #(.Words(MemWords)) i_bank (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .widx_i (mem_idx),
    .wdata_i(req_i.w.data),
    .be_i   (req_i.w.strb),
    .ridx_i (mem_idx),
    .rdata_o(mem_rdata)
  );

  // Transaction state register; pointer resets to favour writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      burst_q  <= '0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
    end
  end

  // Arbitration, burst sequencing, error tracking and channel outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    resp_o   = '0;
    mem_we   = 1'b0;
    grant_w  = 1'b0;
    grant_r  = 1'b0;
    mism     = 1'b0;
    slv_beat = slverr_q;
    dec_beat = decerr_q | ~in_range;
    unique case (state_q)
      IDLE: begin
        grant_w = req_i.aw_valid & (~req_i.ar_valid | ptr_q);
        grant_r = req_i.ar_valid & ~grant_w;
        resp_o.aw_ready = grant_w;
        resp_o.ar_ready = grant_r;
        if (grant_w) begin
          id_d     = req_i.aw.id;
          addr_d   = {1'b0, req_i.aw.addr};
          len_d    = req_i.aw.len;
          burst_d  = req_i.aw.burst;
          beat_d   = '0;
          slverr_d = attr_err(req_i.aw.burst, req_i.aw.size, req_i.aw.len, req_i.aw.atop);
          decerr_d = 1'b0;
          ptr_d    = ~ptr_q;
          state_d  = WDATA;
        end else if (grant_r) begin
          id_d     = req_i.ar.id;
          addr_d   = {1'b0, req_i.ar.addr};
          len_d    = req_i.ar.len;
          burst_d  = req_i.ar.burst;
          beat_d   = '0;
          slverr_d = attr_err(req_i.ar.burst, req_i.ar.size, req_i.ar.len, 6'd0);
          decerr_d = 1'b0;
          ptr_d    = ~ptr_q;
          state_d  = RDATA;
        end
      end
      WDATA: begin
        resp_o.w_ready = 1'b1;
        if (req_i.w_valid) begin
          // A beat whose own error is detected here is not written either.
          mism     = req_i.w.last ? (beat_q < len_q) : (beat_q >= len_q);
          slv_beat = slverr_q | mism;
          mem_we   = ~slv_beat & ~dec_beat;
          slverr_d = slv_beat;
          decerr_d = dec_beat;
          beat_d   = beat_next;
          addr_d   = addr_next;
          if (req_i.w.last) state_d = WRESP;
        end
      end
      WRESP: begin
        resp_o.b_valid = 1'b1;
        resp_o.b.id    = id_q;
        resp_o.b.resp  = err_code(slverr_q, decerr_q);
        if (req_i.b_ready) state_d = IDLE;
      end
      RDATA: begin
        resp_o.r_valid = 1'b1;
        resp_o.r.id    = id_q;
        resp_o.r.data  = (slverr_q | dec_beat) ? 64'd0 : mem_rdata;
        resp_o.r.resp  = {2'b00, err_code(slverr_q, dec_beat)};
        resp_o.r.last  = (beat_q == len_q);
        if (req_i.r_ready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d   = beat_next;
            addr_d   = addr_next;
            decerr_d = dec_beat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      resp_o = '0;
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_culsans_axi_mem_responder.sv
// Randomised and directed bench for culsans_axi_mem_responder with a
// beat-level reference model of the memory and its error rules.
module tb_culsans_axi_mem_responder;
  import culsans_pkg::*;

  localparam int unsigned MW   = 4096;
  localparam logic [63:0] BASE = DRAMBase;
  localparam int          TO   = 200;

  logic      clk = 1'b0;
  logic      rst;
  req_slv_t  req;
  resp_slv_t resp;

  always #5 clk = ~clk;

  culsans_axi_mem_responder #(.MemWords(MW), .BaseAddr(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .resp_o(resp)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] model [longint unsigned];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic        wl [256];
  int          nw;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  int          b_lat, ar_lat;
  logic [63:0] rd [256];
  logic [3:0]  rr [256];
  logic        rl [256];
  logic [3:0]  rid [256];
  int          nr, r_lat, stab_err;
  logic [63:0] ed [256];
  logic [3:0]  er [256];

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 65'(MW) * 65'd8));
  endfunction

  task automatic model_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] atop, output logic [1:0] exp);
    bit slv, dec;
    logic [63:0] a, w;
    longint unsigned idx;
    slv = (burst == 2'b10) || (size < 3 && len != 0) || (size > 3) || (atop != 0);
    dec = 0;
    a = addr;
    for (int i = 0; i < nw; i++) begin
      slv = slv | (wl[i] ? (i < int'(len)) : (i >= int'(len)));
      dec = dec | !in_rng(a);
      if (!slv && !dec) begin
        idx = longint'((a - BASE) >> 3);
        w = model.exists(idx) ? model[idx] : 64'd0;
        for (int b = 0; b < 8; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        model[idx] = w;
      end
      if (burst == 2'b01) a = a + 64'd8;
      if (wl[i]) break;
    end
    exp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endtask

  task automatic model_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
    bit slv, dec;
    logic [63:0] a;
    longint unsigned idx;
    slv = (burst == 2'b10) || (size < 3 && len != 0) || (size > 3);
    dec = 0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      dec = dec | !in_rng(a);
      idx = longint'((a - BASE) >> 3);
      if (slv || dec) ed[i] = 64'd0;
      else ed[i] = model.exists(idx) ? model[idx] : 64'hx;
      er[i] = dec ? 4'd3 : (slv ? 4'd2 : 4'd0);
      if (burst == 2'b01) a = a + 64'd8;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
    int k = 1;
    req.aw = '0;
    req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
    req.aw.size = size; req.aw.burst = burst; req.aw.atop = atop;
    req.aw_valid = 1'b1;
    @(negedge clk);
    while (!resp.aw_ready && k < TO) begin @(negedge clk); k++; end
    n_chk++;
    if (!resp.aw_ready) begin n_fail++; $display("FAIL aw_handshake: no aw_ready after %0d cycles", k); end
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
  endtask

  task automatic send_w();
    for (int i = 0; i < nw; i++) begin
      int k = 1;
      req.w.data = wd[i]; req.w.strb = ws[i]; req.w.last = wl[i]; req.w.user = 1'b0;
      req.w_valid = 1'b1;
      @(negedge clk);
      while (!resp.w_ready && k < TO) begin @(negedge clk); k++; end
      n_chk++;
      if (!resp.w_ready) begin n_fail++; $display("FAIL w_handshake beat %0d: w_ready=0 after %0d cycles", i, k); end
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
  endtask

  task automatic wait_b();
    req.b_ready = 1'b1;
    b_lat = 0;
    do begin @(negedge clk); b_lat++; end while (!resp.b_valid && b_lat < TO);
    b_id = resp.b.id;
    b_resp = resp.b.resp;
    n_chk++;
    if (!resp.b_valid) begin n_fail++; $display("FAIL b_timeout: b_valid=0 after %0d cycles", b_lat); end
    @(posedge clk); #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    req.ar = '0;
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len; req.ar.size = size; req.ar.burst = burst;
    req.ar_valid = 1'b1;
    ar_lat = 1;
    @(negedge clk);
    while (!resp.ar_ready && ar_lat < TO) begin @(negedge clk); ar_lat++; end
    n_chk++;
    if (!resp.ar_ready) begin n_fail++; $display("FAIL ar_handshake: no ar_ready after %0d cycles", ar_lat); end
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  // mode 0: r_ready high, 1: toggling 1,0,1,0, 2: random. abort_at>=0 asserts rst at that beat.
  task automatic collect_r(input int mode, input int abort_at);
    int k = 0, cyc = 0;
    bit done = 0, held = 0;
    r_chan_t held_r;
    nr = 0; r_lat = 0; stab_err = 0;
    while (!done && k < TO) begin
      req.r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      k++; cyc++;
      if (resp.r_valid) begin
        if (r_lat == 0) r_lat = k;
        if (held && resp.r !== held_r) stab_err++;
        if (abort_at >= 0 && nr == abort_at) begin
          rst = 1'b1;
          done = 1;
        end else if (req.r_ready) begin
          rd[nr] = resp.r.data; rr[nr] = resp.r.resp; rl[nr] = resp.r.last; rid[nr] = resp.r.id;
          nr++;
          held = 0;
          if (resp.r.last || nr >= 256) done = 1;
        end else begin
          held = 1;
          held_r = resp.r;
        end
      end
      if (!(abort_at >= 0 && done)) begin @(posedge clk); #1; end
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL r_timeout: %0d beats seen after %0d cycles", nr, k); end
    if (abort_at < 0) req.r_ready = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [3:0] id, input logic [7:0] len);
    n_chk++;
    if (nr !== int'(len) + 1) begin n_fail++; $display("FAIL %s beats: got %0d want %0d", name, nr, int'(len) + 1); end
    for (int i = 0; i < nr && i <= int'(len); i++) begin
      n_chk++;
      if (rd[i] !== ed[i] || rr[i] !== er[i] || rl[i] !== (i == int'(len)) || rid[i] !== id) begin
        n_fail++;
        $display("FAIL %s beat %0d: data=%h resp=%0d last=%0b id=%0d want data=%h resp=%0d last=%0b id=%0d",
                 name, i, rd[i], rr[i], rl[i], rid[i], ed[i], er[i], (i == int'(len)), id);
      end
    end
    n_chk++;
    if (stab_err != 0) begin n_fail++; $display("FAIL %s stability: %0d payload changes while stalled, want 0", name, stab_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req.aw_valid = 1'b1; req.ar_valid = 1'b1; req.w_valid = 1'b1; req.aw.id = 4'd7;
    @(negedge clk);
    n_chk++;
    if (resp !== '0) begin n_fail++; $display("FAIL reset_outputs: resp=%h want 0", resp); end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b0) begin
      n_fail++; $display("FAIL idle_handshakes: got %b want 00000",
                         {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [1:0] exp;
    nw = 1; wd[0] = 64'hDEAD_BEEF_0123_4567; ws[0] = 8'hFF; wl[0] = 1'b1;
    model_write(64'h8000_0010, 8'd0, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd5, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    n_chk++;
    if (b_id !== 4'd5 || b_resp !== exp || b_lat !== 1) begin
      n_fail++; $display("FAIL single_b: id=%0d resp=%0d lat=%0d want id=5 resp=%0d lat=1", b_id, b_resp, b_lat, exp);
    end
    send_ar(4'd6, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
    collect_r(0, -1);
    model_read(64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
    check_read("single_r", 4'd6, 8'd0);
    n_chk++;
    if (rd[0] !== 64'hDEAD_BEEF_0123_4567 || r_lat !== 1) begin
      n_fail++; $display("FAIL single_r_direct: data=%h lat=%0d want deadbeef01234567 lat=1", rd[0], r_lat);
    end
  endtask

  task automatic test_incr_backpressure();
    logic [1:0] exp;
    nw = 4;
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; wl[i] = (i == 3); end
    model_write(64'h8000_0100, 8'd3, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd1, 64'h8000_0100, 8'd3, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    n_chk++;
    if (b_resp !== 2'b00) begin n_fail++; $display("FAIL incr_b: resp=%0d want 0", b_resp); end
    send_ar(4'd2, 64'h8000_0100, 8'd3, 3'd3, BURST_INCR);
    collect_r(1, -1);
    model_read(64'h8000_0100, 8'd3, 3'd3, BURST_INCR);
    check_read("incr_r", 4'd2, 8'd3);
  endtask

  task automatic test_strobe();
    logic [1:0] exp;
    nw = 1; wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF; wl[0] = 1'b1;
    model_write(64'h8000_0200, 8'd0, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd3, 64'h8000_0200, 8'd0, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    wd[0] = 64'd0; ws[0] = 8'h0F;
    model_write(64'h8000_0200, 8'd0, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd3, 64'h8000_0200, 8'd0, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    send_ar(4'd4, 64'h8000_0200, 8'd0, 3'd3, BURST_INCR);
    collect_r(0, -1);
    n_chk++;
    if (rd[0] !== 64'hFFFF_FFFF_0000_0000) begin
      n_fail++; $display("FAIL strobe_merge: data=%h want ffffffff00000000", rd[0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] exp;
    send_ar(4'd8, 64'h7FFF_FFF8, 8'd0, 3'd3, BURST_INCR);
    collect_r(0, -1);
    n_chk++;
    if (nr !== 1 || rr[0] !== 4'd3 || rd[0] !== 64'd0 || rl[0] !== 1'b1) begin
      n_fail++; $display("FAIL decerr_read: beats=%0d resp=%0d data=%h last=%0b want 1/3/0/1", nr, rr[0], rd[0], rl[0]);
    end
    nw = 1; wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF; wl[0] = 1'b1;
    model_write(64'h8000_0010, 8'd0, 3'd3, BURST_WRAP, 6'd0, exp);
    send_aw(4'd9, 64'h8000_0010, 8'd0, 3'd3, BURST_WRAP, 6'd0);
    send_w();
    wait_b();
    n_chk++;
    if (b_resp !== 2'b10 || b_id !== 4'd9) begin n_fail++; $display("FAIL wrap_b: resp=%0d id=%0d want 2/9", b_resp, b_id); end
    send_ar(4'd10, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
    collect_r(0, -1);
    n_chk++;
    if (rd[0] !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL wrap_unchanged: data=%h want deadbeef01234567", rd[0]); end
    nw = 1; wl[0] = 1'b1;
    model_write(64'h8000_0300, 8'd1, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd11, 64'h8000_0300, 8'd1, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    n_chk++;
    if (b_resp !== 2'b10 || b_lat !== 1) begin n_fail++; $display("FAIL early_last_b: resp=%0d lat=%0d want 2/1", b_resp, b_lat); end
    model_write(64'h8000_0308, 8'd0, 3'd3, BURST_INCR, 6'h20, exp);
    send_aw(4'd12, 64'h8000_0308, 8'd0, 3'd3, BURST_INCR, 6'h20);
    send_w();
    wait_b();
    n_chk++;
    if (b_resp !== exp || exp !== 2'b10) begin n_fail++; $display("FAIL atop_b: resp=%0d want %0d", b_resp, exp); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    bit ptr, got_w, want_w;
    logic [3:0]  gid;
    logic [63:0] gaddr;
    logic [3:0]  next_aw_id;
    pulse_reset();
    ptr = 1;
    next_aw_id = 4'd1;
    req.aw = '0; req.aw.id = 4'd1; req.aw.addr = 64'h8000_0400; req.aw.size = 3'd3; req.aw.burst = BURST_INCR;
    req.ar = '0; req.ar.id = 4'd2; req.ar.addr = 64'h8000_0010; req.ar.size = 3'd3; req.ar.burst = BURST_INCR;
    req.aw_valid = 1'b1; req.ar_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      int k = 1;
      @(negedge clk);
      while (!(resp.aw_ready || resp.ar_ready) && k < TO) begin @(negedge clk); k++; end
      got_w = resp.aw_ready;
      want_w = ptr;
      ptr = ~ptr;
      n_chk++;
      if (got_w !== want_w || !(resp.aw_ready || resp.ar_ready)) begin
        n_fail++; $display("FAIL arb_grant %0d: write_grant=%0b want %0b", t, got_w, want_w);
      end
      gid = got_w ? req.aw.id : req.ar.id;
      gaddr = req.aw.addr;
      @(posedge clk); #1;
      if (got_w) begin
        next_aw_id = next_aw_id + 4'd2;
        req.aw.id = next_aw_id;
        req.aw.addr = req.aw.addr + 64'd8;
      end
      if (t == 2) begin req.aw_valid = 1'b0; req.ar_valid = 1'b0; end
      if (got_w) begin
        nw = 1; wd[0] = {32'hA5A5_0000, 32'(t)}; ws[0] = 8'hFF; wl[0] = 1'b1;
        model_write(gaddr, 8'd0, 3'd3, BURST_INCR, 6'd0, exp);
        send_w();
        wait_b();
        n_chk++;
        if (b_id !== gid || b_resp !== exp) begin
          n_fail++; $display("FAIL arb_b %0d: id=%0d resp=%0d want id=%0d resp=%0d", t, b_id, b_resp, gid, exp);
        end
      end else begin
        collect_r(0, -1);
        model_read(64'h8000_0010, 8'd0, 3'd3, BURST_INCR);
        check_read("arb_r", gid, 8'd0);
      end
    end
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0]  exp, burst;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [63:0] addr;
    nw = 32;
    for (int i = 0; i < 32; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; wl[i] = (i == 31); end
    model_write(64'h8000_2000, 8'd31, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd0, 64'h8000_2000, 8'd31, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    n_chk++;
    if (b_resp !== exp) begin n_fail++; $display("FAIL prefill_b: resp=%0d want %0d", b_resp, exp); end
    for (int t = 0; t < 40; t++) begin
      id    = 4'($urandom);
      len   = 8'($urandom_range(0, 3));
      burst = ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR;
      size  = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
      addr  = ($urandom_range(0, 7) == 0) ? BASE - 64'd8 : 64'h8000_2000 + 64'(8 * $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) begin
        nw = int'(len) + 1;
        if (len != 0 && $urandom_range(0, 5) == 0) nw = $urandom_range(1, int'(len));
        else if ($urandom_range(0, 7) == 0) nw = int'(len) + 2;
        for (int i = 0; i < nw; i++) begin
          wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); wl[i] = (i == nw - 1);
        end
        model_write(addr, len, size, burst, 6'd0, exp);
        send_aw(id, addr, len, size, burst, 6'd0);
        send_w();
        wait_b();
        n_chk++;
        if (b_id !== id || b_resp !== exp) begin
          n_fail++; $display("FAIL rand_b %0d: id=%0d resp=%0d want id=%0d resp=%0d", t, b_id, b_resp, id, exp);
        end
      end else begin
        model_read(addr, len, size, burst);
        send_ar(id, addr, len, size, burst);
        collect_r(2, -1);
        check_read("rand_r", id, len);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] exp;
    bit stray;
    nw = 8;
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; wl[i] = (i == 7); end
    model_write(64'h8000_0500, 8'd7, 3'd3, BURST_INCR, 6'd0, exp);
    send_aw(4'd13, 64'h8000_0500, 8'd7, 3'd3, BURST_INCR, 6'd0);
    send_w();
    wait_b();
    send_ar(4'd9, 64'h8000_0500, 8'd7, 3'd3, BURST_INCR);
    collect_r(0, 2);
    #1;
    n_chk++;
    if (resp.r_valid !== 1'b0 || resp !== '0) begin
      n_fail++; $display("FAIL rst_mid_read: r_valid=%0b resp=%h want 0", resp.r_valid, resp);
    end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp.r_valid || resp.b_valid) stray = 1;
    end
    n_chk++;
    if (stray) begin n_fail++; $display("FAIL rst_stray_resp: B or R after reset, want none"); end
    @(posedge clk); #1;
    send_ar(4'd10, 64'h8000_0500, 8'd7, 3'd3, BURST_INCR);
    n_chk++;
    if (ar_lat !== 1) begin n_fail++; $display("FAIL rst_idle: ar accepted after %0d cycles want 1", ar_lat); end
    collect_r(0, -1);
    model_read(64'h8000_0500, 8'd7, 3'd3, BURST_INCR);
    check_read("rst_reread", 4'd10, 8'd7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_incr_backpressure();
    test_strobe();
    test_errors();
    test_arbitration();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/culsans_axi_mem_responder.md
Name: culsans_axi_mem_responder

Overview:
- AXI/ACE subordinate-side memory model that sits on a crossbar master port and answers req_slv_t traffic with resp_slv_t.
- Serves the DRAM window, including the exit word at DRAMBase+exitOffset, for simulation and small FPGA builds.
- Handles one transaction at a time. Reads and writes are arbitrated round-robin.
- ACE snoop, bar and domain fields are accepted and ignored. Read responses always carry IsShared=0 and PassDirty=0.

Parameters:
- MemWords, 4096, number of 64-bit storage words; must be a power of two.
- BaseAddr, culsans_pkg::DRAMBase, byte address of word 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock domain, asynchronous, active-high.
- req_i  in  culsans_pkg::req_slv_t  AW/W/AR channels plus b_ready and r_ready from the crossbar.
- resp_o  out  culsans_pkg::resp_slv_t  ready signals plus B/R channels to the crossbar.

Behaviour:
- Reset state:
  - All resp_o valid and ready bits are 0, and all resp_o payload fields are 0.
  - FSM goes to IDLE and the round-robin pointer favours write.
  - Storage is not cleared.
  - Reset asserted mid-burst abandons the transaction; no B or R is emitted for it afterwards.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - aw_ready = aw_valid & grant_w and ar_ready = ar_valid & ~grant_w.
  - If only one valid is high, that channel is granted.
  - If both are high, the pointer decides, and the pointer toggles after every grant.
  - On an AW handshake, latch id, addr, len, burst, size and atop, set beat_cnt=0, and go to WDATA.
  - On an AR handshake, latch the same fields and go to RDATA.
- Word index: (addr − BaseAddr) >> 3. An address is in range iff BaseAddr ≤ addr < BaseAddr + 8·MemWords; compute in 64 bits with no wrap.
- Per-beat address:
  - INCR: the word index increments by 1 after each beat.
  - FIXED: the word index does not change.
  - WRAP: the transaction is flagged error.
  - A beat whose word index leaves the range is flagged DECERR.
- Error flags (sticky per transaction, priority DECERR > SLVERR):
  - DECERR for an out-of-range beat.
  - SLVERR for any of: WRAP burst; size < 3 with len > 0; size > 3; atop ≠ 0; write beat count mismatch with w.last.
- WDATA:
  - w_ready = 1.
  - Each W handshake writes the bytes selected by strb, unless the transaction is flagged or the beat is out of range (then no write).
  - The beat with w.last=1 ends the burst regardless of len.
  - A mismatch means last=1 arriving early, or beat_cnt reaching len with last=0; a last=0 beat past len is still consumed.
  - After the last beat go to WRESP.
- WRESP:
  - b_valid=1 starting the cycle after the last W handshake.
  - b.id is the latched id; b.resp is OKAY, SLVERR or DECERR; b.user=0.
  - Hold until b_ready, then go to IDLE.
- RDATA:
  - r_valid=1 starting the cycle after the AR handshake.
  - r.data is the storage word at the current index, read combinationally from the flop array; it is 0 for an out-of-range or flagged beat.
  - r.resp[1:0] is the error code; r.resp[3:2]=0.
  - r.last=1 when beat_cnt==len.
  - The beat advances on r_ready. After the last beat go to IDLE.
- Payload stability: all channel payloads are stable while valid is high and ready is low.
- Throughput:
  - Minimum of one cycle in IDLE between transactions.
  - W: one beat per cycle.
  - R: one beat per cycle when r_ready is held high.
- Same-cycle write/read: a write that completes the cycle before a read is granted is visible to that read.

Decomposition:
- Add to culsans_pkg: typedef resp_code_t for OKAY/SLVERR/DECERR, and localparam MemRespWordBytes=8.
- One sub-module, culsans_mem_bank: a byte-enabled flop array with a single write port (we, widx, wdata, be) and a combinational read port (ridx → rdata).
- FSM, arbiter and burst counter live in the top module.

Test Plan:
- Single write then read:
  - Stimulus: AW id=5, addr=0x8000_0010, len=0, size=3; W data=0xDEAD_BEEF_0123_4567, strb=0xFF; then AR to the same address.
  - Required: B id=5 OKAY one cycle after the W handshake; R data=0xDEAD_BEEF_0123_4567, resp=0, last=1, one cycle after the AR handshake.
- INCR burst with backpressure:
  - Stimulus: write len=3 at 0x8000_0100 with data 1,2,3,4; read back len=3 with r_ready toggling 1,0,1,0.
  - Required: four beats 1,2,3,4 with last only on the 4th, and data held stable while r_ready=0.
- Strobe merge:
  - Stimulus: word preset to 0xFFFF_FFFF_FFFF_FFFF; write 0 with strb=0x0F; read back.
  - Required: 0xFFFF_FFFF_0000_0000.
- Errors:
  - AR at 0x7FFF_FFF8 → DECERR, data=0.
  - Write with burst=WRAP → B SLVERR and storage unchanged.
  - Write with len=1 and w.last=1 on beat 0 → B SLVERR after one beat.
- Arbitration:
  - Stimulus: AW and AR asserted together in IDLE, held for three transactions.
  - Required: grants alternate write, read, write; ids are echoed correctly.
- Reset mid-read:
  - Stimulus: assert rst_i during beat 2 of a len=7 read.
  - Required: r_valid=0 immediately, the FSM is in IDLE after release, storage is retained, and a new AR is serviced normally.
